// File: rtl/alu_seq.sv
// alu_seq: single-issue ALU with valid/ready handshakes on both sides.
// Non-shift ops complete on the accept edge. lsl/lsr shift one bit per
// cycle, so a shift by s takes 1+s cycles to produce its result.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rx,
  input  logic [WIDTH-1:0] ry,
  input  logic [WIDTH-1:0] mem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam int CW = $clog2(WIDTH) + 1;   // counter holds 0..WIDTH
  localparam int M  = WIDTH - 1;
  localparam logic [CW-1:0]    SMAX = CW'(WIDTH);
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  localparam logic [3:0] OP_LSL = 4'b0111;
  localparam logic [3:0] OP_LSR = 4'b1000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             left;

  logic             accept, is_shift;
  logic [CW-1:0]    s;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] res;
  logic             rc, rv;
  logic [WIDTH-1:0] acc_nx;
  logic             sbit;

  // A draining DONE cycle can take the next request on the same edge.
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign is_shift = (op == OP_LSL) | (op == OP_LSR);
  // Shifting WIDTH or more positions all yields zero; cap to bound latency.
  assign s        = (ry >= WLIM) ? SMAX : CW'(ry);

  // Single-cycle result and flags for the op presented at the input.
  always_comb begin
    sum = {1'b0, rx} + {1'b0, ry};
    dif = {1'b0, rx} - {1'b0, ry};
    res = rx;
    rc  = 1'b0;
    rv  = 1'b0;
    case (op)
      4'b0000: res = '0;
      4'b0001: begin
        res = sum[M:0];
        rc  = sum[WIDTH];
        rv  = (rx[M] == ry[M]) && (res[M] != rx[M]);
      end
      4'b0010: begin
        res = dif[M:0];
        rc  = dif[WIDTH];                 // borrow: rx < ry unsigned
        rv  = (rx[M] != ry[M]) && (res[M] != rx[M]);
      end
      4'b0011: res = rx & ry;
      4'b0100: res = rx | ry;
      4'b0101: res = rx ^ ry;
      4'b0110: res = ~rx;
      4'b1110: res = mem;
      default: res = rx;                  // includes zero-count shifts
    endcase
  end

  // One shift step; sbit is the bit falling off the end.
  always_comb begin
    acc_nx = left ? {acc[M-1:0], 1'b0} : {1'b0, acc[M:1]};
    sbit   = left ? acc[M] : acc[0];
  end

  // Control FSM plus registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      left      <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      {z, n, c, v} <= 4'b0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_shift && (s != '0)) begin
              acc       <= rx;
              cnt       <= s;
              left      <= (op == OP_LSL);
              out_valid <= 1'b0;
              state     <= SHIFT;
            end else begin
              out       <= res;
              z         <= (res == '0);
              n         <= res[M];
              c         <= rc;
              v         <= rv;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        SHIFT: begin
          acc <= acc_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            out       <= acc_nx;
            z         <= (acc_nx == '0);
            n         <= acc_nx[M];
            c         <= sbit;
            v         <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=4 instance for the functional vectors
// and a WIDTH=8 instance for reset during a long shift.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       rst, in_valid, in_ready, out_valid, out_ready, z, n, c, v;
  logic [3:0] op, rx, ry, mem, out;

  // WIDTH=8 instance
  logic       b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic       b_z, b_n, b_c, b_v;
  logic [3:0] b_op;
  logic [7:0] b_rx, b_ry, b_mem, b_out;

  int cmp = 0;
  int mis = 0;

  alu_seq #(.WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rx(rx), .ry(ry), .mem(mem), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .z(z), .n(n), .c(c), .v(v));

  alu_seq #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
    .rx(b_rx), .ry(b_ry), .mem(b_mem), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out), .z(b_z), .n(b_n), .c(b_c), .v(b_v));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the edge; outputs read at the same point
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request on the 4-bit DUT for exactly one edge.
  task automatic req(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] m);
    op = o; rx = a; ry = b; mem = m; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Single-cycle op: check result, {z,n,c,v} and out_valid right after accept.
  task automatic one(input string tag, input logic [3:0] o, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] eo, input logic [3:0] ef);
    req(o, a, b, 4'h0);
    chk({tag, "_out"}, 32'(out), 32'(eo));
    chk({tag, "_flg"}, 32'({z, n, c, v}), 32'(ef));
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; rx = '0; ry = '0; mem = '0; out_ready = 1'b1;
    b_rst = 1'b1; b_in_valid = 1'b0; b_op = '0; b_rx = '0; b_ry = '0; b_mem = '0;
    b_out_ready = 1'b1;
    step(); step();
    rst = 1'b0; b_rst = 1'b0;

    // reset state
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_flg", 32'({z, n, c, v}), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);

    // add overflow into sign bit; then two subs back to back while draining
    one("add7p1", 4'b0001, 4'h7, 4'h1, 4'h8, 4'b0101);
    one("sub2m3", 4'b0010, 4'h2, 4'h3, 4'hF, 4'b0110);
    one("sub5m5", 4'b0010, 4'h5, 4'h5, 4'h0, 4'b1000);
    step();
    chk("drain_vld", 32'(out_valid), 32'd0);
    chk("drain_hold", 32'({out, z, n, c, v}), 32'({4'h0, 4'b1000}));

    // logic ops, default opcodes, zero-count shift, add with carry+overflow
    one("and",   4'b0011, 4'hC, 4'hA, 4'h8, 4'b0100);
    one("or",    4'b0100, 4'hC, 4'hA, 4'hE, 4'b0100);
    one("xor",   4'b0101, 4'hC, 4'hA, 4'h6, 4'b0000);
    one("not",   4'b0110, 4'hC, 4'hA, 4'h3, 4'b0000);
    one("zero",  4'b0000, 4'hC, 4'hA, 4'h0, 4'b1000);
    one("op9",   4'b1001, 4'hC, 4'hA, 4'hC, 4'b0100);
    one("opF",   4'b1111, 4'h5, 4'hA, 4'h5, 4'b0000);
    one("add9p8", 4'b0001, 4'h9, 4'h8, 4'h1, 4'b0011);
    one("lsl0",  4'b0111, 4'hC, 4'h0, 4'hC, 4'b0100);
    step();

    // lsl 0011 by 3 -> 1000; last bit out is original bit 1, so c=1
    req(4'b0111, 4'h3, 4'h3, 4'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lsl_rdy%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("lsl_vld%0d", i), 32'(out_valid), 32'd0);
      step();
    end
    chk("lsl_vld", 32'(out_valid), 32'd1);
    chk("lsl_out", 32'(out), 32'h8);
    chk("lsl_flg", 32'({z, n, c, v}), 32'b0110);

    // lsr 1001 by 7 (capped at 4), accepted while draining the lsl result
    req(4'b1000, 4'h9, 4'h7, 4'h0);
    chk("lsr_vld0", 32'(out_valid), 32'd0);
    step(); step(); step();
    chk("lsr_vld3", 32'(out_valid), 32'd0);
    step();
    chk("lsr_vld", 32'(out_valid), 32'd1);
    chk("lsr_out", 32'(out), 32'h0);
    chk("lsr_flg", 32'({z, n, c, v}), 32'b1010);
    step();

    // backpressure: result holds; a request while not ready is dropped
    out_ready = 1'b0;
    req(4'b0001, 4'h3, 4'h4, 4'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin op = 4'b0000; in_valid = 1'b1; end
      chk($sformatf("hold%0d", i), 32'({out_valid, out, z, n, c, v}),
          32'({1'b1, 4'h7, 4'b0000}));
      chk($sformatf("hold_rdy%0d", i), 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    chk("hold_end", 32'({out_valid, out}), 32'({1'b1, 4'h7}));
    out_ready = 1'b1;
    req(4'b1110, 4'h3, 4'h4, 4'hA);
    chk("mem_out", 32'({out_valid, out}), 32'({1'b1, 4'hA}));
    chk("mem_flg", 32'({z, n, c, v}), 32'b0100);
    step();
    chk("mem_drain", 32'(out_valid), 32'd0);

    // WIDTH=8: leave a nonzero result, then reset in the 3rd SHIFT cycle
    b_op = 4'b0001; b_rx = 8'h7F; b_ry = 8'h01; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    chk("b_add_out", 32'(b_out), 32'h80);
    chk("b_add_flg", 32'({b_z, b_n, b_c, b_v}), 32'b0101);
    step();
    b_op = 4'b0111; b_rx = 8'h81; b_ry = 8'd6; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    chk("b_sh_vld0", 32'(b_out_valid), 32'd0);
    step();
    chk("b_sh_vld1", 32'(b_out_valid), 32'd0);
    step();
    chk("b_sh_vld2", 32'(b_out_valid), 32'd0);
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    chk("b_rst_rdy", 32'(b_in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_rst_q%0d", i), 32'({b_out_valid, b_out, b_z, b_n, b_c, b_v}), 32'd0);
      step();
    end
    chk("b_rst_rdy2", 32'(b_in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
